// File: rtl/cpmg_pkg.sv
// ----------------------------------------------------------------------------
// cpmg_pkg
// Shared definitions for the CPMG pulse sequencer: parameter width, state
// codes, rf_phase encodings, the latched scan configuration record and the
// helpers that resolve which timed state follows a given point in the scan
// once zero-length states are skipped.
// Optional feature macro (used by the files importing this package):
//   CPMG_T1_PRELUDE_EN - enables the T1 inversion-recovery prelude.
// ----------------------------------------------------------------------------
package cpmg_pkg;

    localparam int PARAM_W = 32;

    typedef logic [PARAM_W-1:0] dur_t;

    // State codes. The setup states are numbered in scan order so that
    // setup_state_from() can compare them with <=.
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T1P  = 4'd1;
    localparam logic [3:0] S_T1D  = 4'd2;
    localparam logic [3:0] S_P90  = 4'd3;
    localparam logic [3:0] S_TAU  = 4'd4;
    localparam logic [3:0] S_P180 = 4'd5;
    localparam logic [3:0] S_DNS  = 4'd6;
    localparam logic [3:0] S_SIG  = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    localparam logic RF_PHASE_90  = 1'b0;
    localparam logic RF_PHASE_180 = 1'b1;

    typedef struct packed {
        dur_t t1p;
        dur_t t1d;
        dur_t p90;
        dur_t tau;
        dur_t p180;
        dur_t dns;
        dur_t sig;
        dur_t echoes;
    } scan_cfg_t;

    // First non-empty state of an echo. Only called when the echo has at
    // least one non-zero duration, so SIG is the final fallback.
    function automatic logic [3:0] first_echo_state(scan_cfg_t c);
        logic [3:0] s;
        if (c.p180 != '0)     s = S_P180;
        else if (c.dns != '0) s = S_DNS;
        else                  s = S_SIG;
        return s;
    endfunction

    // Where the scan goes after TAU. An echo whose three durations are all
    // zero takes no time at all, so the loop collapses straight to DONE.
    function automatic logic [3:0] loop_entry_state(scan_cfg_t c);
        logic [3:0] s;
        if (c.echoes == '0 || (c.p180 == '0 && c.dns == '0 && c.sig == '0))
            s = S_DONE;
        else
            s = first_echo_state(c);
        return s;
    endfunction

    // First non-zero setup state at or after candidate 'cand'. Checked from
    // the latest state back to the earliest so the earliest eligible wins.
    function automatic logic [3:0] setup_state_from(logic [3:0] cand, scan_cfg_t c);
        logic [3:0] s;
        s = loop_entry_state(c);
        if (cand <= S_TAU && c.tau != '0) s = S_TAU;
        if (cand <= S_P90 && c.p90 != '0) s = S_P90;
        if (cand <= S_T1D && c.t1d != '0) s = S_T1D;
        if (cand <= S_T1P && c.t1p != '0) s = S_T1P;
        return s;
    endfunction

    // Cycle count a state occupies; untimed states load zero.
    function automatic dur_t state_duration(logic [3:0] s, scan_cfg_t c);
        dur_t d;
        case (s)
            S_T1P:   d = c.t1p;
            S_T1D:   d = c.t1d;
            S_P90:   d = c.p90;
            S_TAU:   d = c.tau;
            S_P180:  d = c.p180;
            S_DNS:   d = c.dns;
            S_SIG:   d = c.sig;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpmg_dur_cnt.sv
// ----------------------------------------------------------------------------
// cpmg_dur_cnt
// Loadable 32-bit down-counter timing each sequencer state. Loaded with the
// state's duration on entry; 'last' is high during the final cycle of the
// state (count == 1). Counting stops at zero and never wraps.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, clears the count
//   load  - load 'value' on this edge (state entry)
//   value - duration to load, in cycles
//   last  - high while the count equals 1
// ----------------------------------------------------------------------------
module cpmg_dur_cnt
    import cpmg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PARAM_W-1:0] value,
    output logic               last
);

    logic [PARAM_W-1:0] cnt_q;
    logic [PARAM_W-1:0] cnt_d;

    always_comb begin
        // NOTE: cnt_d is given a default first so every path assigns it and
        // no latch is inferred.
        cnt_d = cnt_q;
        if (load)
            cnt_d = value;
        else if (cnt_q != '0)
            cnt_d = cnt_q - PARAM_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign last = (cnt_q == PARAM_W'(1));

endmodule

// File: rtl/cpmg_sequencer.sv
// ----------------------------------------------------------------------------
// cpmg_sequencer
// CPMG NMR pulse sequencer: IDLE -> [T1P -> T1D] -> P90 -> TAU ->
// {P180 -> DNS -> SIG} x echoes_per_scan -> DONE -> IDLE. Each timed state
// lasts its latched parameter in cycles; zero-length states are skipped.
// All outputs are registered from the next state, so they line up with it.
// Optional feature macro:
//   CPMG_T1_PRELUDE_EN - include the T1 inversion-recovery prelude (T1P, T1D);
//                        without it pulse_t1/delay_t1 are ignored.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   start, abort          - run one scan / terminate the running scan
//   pulse_90deg .. delay_t1 - 32-bit cycle counts, latched on start
//   rf_gate, rf_phase     - transmitter enable and phase (0=90/T1, 1=180)
//   rx_blank, acq_gate    - receiver blanking, ADC acquisition window
//   busy, done, echo_idx  - scan active, one-cycle completion, echo number
// ----------------------------------------------------------------------------
module cpmg_sequencer
    import cpmg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PARAM_W-1:0] pulse_90deg,
    input  logic [PARAM_W-1:0] pulse_180deg,
    input  logic [PARAM_W-1:0] init_delay,
    input  logic [PARAM_W-1:0] delay_nosig,
    input  logic [PARAM_W-1:0] delay_sig,
    input  logic [PARAM_W-1:0] echoes_per_scan,
    input  logic [PARAM_W-1:0] pulse_t1,
    input  logic [PARAM_W-1:0] delay_t1,
    output logic               rf_gate,
    output logic               rf_phase,
    output logic               rx_blank,
    output logic               acq_gate,
    output logic               busy,
    output logic               done,
    output logic [PARAM_W-1:0] echo_idx
);

    logic [PARAM_W-1:0] t1p_in;
    logic [PARAM_W-1:0] t1d_in;

`ifdef CPMG_T1_PRELUDE_EN
    assign t1p_in = pulse_t1;
    assign t1d_in = delay_t1;
`else
    // Prelude compiled out: zero durations make the setup chain skip T1P/T1D.
    logic unused_t1;
    assign t1p_in    = '0;
    assign t1d_in    = '0;
    assign unused_t1 = ^{pulse_t1, delay_t1};
`endif

    scan_cfg_t  cfg_in;
    scan_cfg_t  cfg_q;
    scan_cfg_t  cfg_eff;
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] next_echo;
    dur_t       echo_idx_q;
    logic       last_echo;
    logic       echo_clr;
    logic       echo_inc;
    logic       cnt_load;
    dur_t       cnt_value;
    logic       cnt_last;

    logic rf_gate_q, rf_phase_q, rx_blank_q, acq_gate_q, busy_q, done_q;

    assign cfg_in = '{t1p:    t1p_in,
                      t1d:    t1d_in,
                      p90:    pulse_90deg,
                      tau:    init_delay,
                      p180:   pulse_180deg,
                      dns:    delay_nosig,
                      sig:    delay_sig,
                      echoes: echoes_per_scan};

    // In IDLE the scan about to start is timed from the live inputs (they
    // are latched on that same edge); afterwards only the latched copy counts.
    assign cfg_eff = (state_q == S_IDLE) ? cfg_in : cfg_q;

    assign last_echo = (echo_idx_q == cfg_q.echoes - PARAM_W'(1));
    assign next_echo = last_echo ? S_DONE : first_echo_state(cfg_q);

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        echo_clr = 1'b0;
        echo_inc = 1'b0;
        if (abort) begin
            // Abort also blocks a same-cycle start while idle.
            if (state_q != S_IDLE) begin
                state_d  = S_IDLE;
                cnt_load = 1'b1;
                echo_clr = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d  = setup_state_from(S_T1P, cfg_in);
                    cnt_load = 1'b1;
                    echo_clr = 1'b1;
                end
                S_T1P: if (cnt_last) begin
                    state_d  = setup_state_from(S_T1D, cfg_q);
                    cnt_load = 1'b1;
                end
                S_T1D: if (cnt_last) begin
                    state_d  = setup_state_from(S_P90, cfg_q);
                    cnt_load = 1'b1;
                end
                S_P90: if (cnt_last) begin
                    state_d  = setup_state_from(S_TAU, cfg_q);
                    cnt_load = 1'b1;
                end
                S_TAU: if (cnt_last) begin
                    state_d  = loop_entry_state(cfg_q);
                    cnt_load = 1'b1;
                end
                S_P180: if (cnt_last) begin
                    cnt_load = 1'b1;
                    if (cfg_q.dns != '0)
                        state_d = S_DNS;
                    else if (cfg_q.sig != '0)
                        state_d = S_SIG;
                    else begin
                        state_d  = next_echo;
                        echo_inc = !last_echo;
                    end
                end
                S_DNS: if (cnt_last) begin
                    cnt_load = 1'b1;
                    if (cfg_q.sig != '0)
                        state_d = S_SIG;
                    else begin
                        state_d  = next_echo;
                        echo_inc = !last_echo;
                    end
                end
                S_SIG: if (cnt_last) begin
                    cnt_load = 1'b1;
                    state_d  = next_echo;
                    echo_inc = !last_echo;
                end
                default: begin
                    // DONE lasts one cycle; unused codes recover to IDLE.
                    state_d  = S_IDLE;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    // A transition can re-enter the same state (e.g. SIG -> SIG when P180
    // and DNS are zero), so the counter loads on every taken transition.
    assign cnt_value = state_duration(state_d, cfg_eff);

    cpmg_dur_cnt u_dur_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            echo_idx_q <= '0;
            rf_gate_q  <= 1'b0;
            rf_phase_q <= 1'b0;
            rx_blank_q <= 1'b0;
            acq_gate_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start && !abort)
                cfg_q <= cfg_in;
            if (echo_clr)
                echo_idx_q <= '0;
            else if (echo_inc)
                echo_idx_q <= echo_idx_q + PARAM_W'(1);
            // Outputs decode the next state so they are valid with it.
            rf_gate_q  <= (state_d == S_T1P) || (state_d == S_P90) || (state_d == S_P180);
            rf_phase_q <= (state_d == S_P180) ? RF_PHASE_180 : RF_PHASE_90;
            rx_blank_q <= (state_d == S_T1P) || (state_d == S_P90) ||
                          (state_d == S_P180) || (state_d == S_DNS);
            acq_gate_q <= (state_d == S_SIG);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign rf_gate  = rf_gate_q;
    assign rf_phase = rf_phase_q;
    assign rx_blank = rx_blank_q;
    assign acq_gate = acq_gate_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign echo_idx = echo_idx_q;

endmodule

// File: tb/tb_cpmg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpmg_sequencer
// Self-checking bench for cpmg_sequencer. A reference model expands the scan
// parameters into a per-cycle list of expected outputs (segments of N cycles
// in scan order); directed table vectors, hand sequences for abort, reset and
// parameter stability, and randomized scans are compared against it.
// Honours CPMG_T1_PRELUDE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_cpmg_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [31:0] pulse_90deg, pulse_180deg, init_delay, delay_nosig;
    logic [31:0] delay_sig, echoes_per_scan, pulse_t1, delay_t1;
    logic        rf_gate, rf_phase, rx_blank, acq_gate, busy, done;
    logic [31:0] echo_idx;

    always #5 clk = ~clk;

    cpmg_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .pulse_90deg     (pulse_90deg),
        .pulse_180deg    (pulse_180deg),
        .init_delay      (init_delay),
        .delay_nosig     (delay_nosig),
        .delay_sig       (delay_sig),
        .echoes_per_scan (echoes_per_scan),
        .pulse_t1        (pulse_t1),
        .delay_t1        (delay_t1),
        .rf_gate         (rf_gate),
        .rf_phase        (rf_phase),
        .rx_blank        (rx_blank),
        .acq_gate        (acq_gate),
        .busy            (busy),
        .done            (done),
        .echo_idx        (echo_idx)
    );

    typedef struct packed {
        logic        rf_gate;
        logic        rf_phase;
        logic        rx_blank;
        logic        acq_gate;
        logic        busy;
        logic        done;
        logic [31:0] echo_idx;
    } obs_t;

    typedef struct {
        int unsigned t1p, t1d, p90, tau, p180, dns, sig, echoes;
    } prm_t;

    typedef struct {
        prm_t p;
        int   done_cyc;
        int   acq_cnt;
        int   rf_cnt;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic obs_t sample();
        obs_t r;
        r.rf_gate  = rf_gate;
        r.rf_phase = rf_phase;
        r.rx_blank = rx_blank;
        r.acq_gate = acq_gate;
        r.busy     = busy;
        r.done     = done;
        r.echo_idx = echo_idx;
        return r;
    endfunction

    function automatic prm_t mkp(int unsigned t1p, int unsigned t1d, int unsigned p90,
                                 int unsigned tau, int unsigned p180, int unsigned dns,
                                 int unsigned sig, int unsigned echoes);
        prm_t p;
        p.t1p = t1p; p.t1d = t1d; p.p90 = p90; p.tau = tau;
        p.p180 = p180; p.dns = dns; p.sig = sig; p.echoes = echoes;
        return p;
    endfunction

    function automatic vec_t mkv(prm_t p, int done_cyc, int acq_cnt, int rf_cnt);
        vec_t v;
        v.p = p; v.done_cyc = done_cyc; v.acq_cnt = acq_cnt; v.rf_cnt = rf_cnt;
        return v;
    endfunction

    // Append n busy cycles with the given output levels.
    task automatic push_seg(input logic rf, input logic ph, input logic bl, input logic acq,
                            input int unsigned n, input int unsigned idx);
        obs_t r;
        r.rf_gate  = rf;
        r.rf_phase = ph;
        r.rx_blank = bl;
        r.acq_gate = acq;
        r.busy     = 1'b1;
        r.done     = 1'b0;
        r.echo_idx = idx;
        repeat (n) exp_q.push_back(r);
    endtask

    // Expected outputs for cycles 1.. after a start sampled at edge 0.
    // abort_at > 0: abort is sampled at the end of that cycle.
    task automatic build_model(input prm_t p, input int abort_at);
        int unsigned last_idx;
        obs_t        r;
        exp_q.delete();
        last_idx = 0;
`ifdef CPMG_T1_PRELUDE_EN
        push_seg(1'b1, 1'b0, 1'b1, 1'b0, p.t1p, 0);
        push_seg(1'b0, 1'b0, 1'b0, 1'b0, p.t1d, 0);
`endif
        push_seg(1'b1, 1'b0, 1'b1, 1'b0, p.p90, 0);
        push_seg(1'b0, 1'b0, 1'b0, 1'b0, p.tau, 0);
        if (p.echoes != 0 && (p.p180 + p.dns + p.sig) != 0) begin
            for (int unsigned e = 0; e < p.echoes; e++) begin
                push_seg(1'b1, 1'b1, 1'b1, 1'b0, p.p180, e);
                push_seg(1'b0, 1'b0, 1'b1, 1'b0, p.dns, e);
                push_seg(1'b0, 1'b0, 1'b0, 1'b1, p.sig, e);
            end
            last_idx = p.echoes - 1;
        end
        r = '0;
        r.busy     = 1'b1;
        r.done     = 1'b1;
        r.echo_idx = last_idx;
        exp_q.push_back(r);
        r.busy = 1'b0;
        r.done = 1'b0;
        repeat (3) exp_q.push_back(r);
        if (abort_at > 0) begin
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
            r = '0;
            repeat (4) exp_q.push_back(r);
        end
    endtask

    task automatic drive_params(input prm_t p);
        pulse_t1        = p.t1p;
        delay_t1        = p.t1d;
        pulse_90deg     = p.p90;
        init_delay      = p.tau;
        pulse_180deg    = p.p180;
        delay_nosig     = p.dns;
        delay_sig       = p.sig;
        echoes_per_scan = p.echoes;
    endtask

    // Start one scan and compare every cycle against the model.
    // disturb_at > 0: in that cycle pulse start again and change pulse_180deg.
    task automatic run_scan(input prm_t p, input int abort_at, input int disturb_at,
                            input string tag, output int done_cyc, output int acq_cnt,
                            output int rf_cnt);
        obs_t got;
        build_model(p, abort_at);
        @(negedge clk);
        drive_params(p);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = 0;
        acq_cnt  = 0;
        rf_cnt   = 0;
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge clk);
            got = sample();
            check($sformatf("%s cyc%0d", tag, c), 64'(got), 64'(exp_q[c-1]));
            if (got.done && done_cyc == 0) done_cyc = c;
            acq_cnt += int'(got.acq_gate);
            rf_cnt  += int'(got.rf_gate);
            abort = (c == abort_at);
            if (c == disturb_at) begin
                start        = 1'b1;
                pulse_180deg = pulse_180deg + 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int   dc, ac, rc;
        int   seen_done;
        prm_t p0;
        prm_t pr;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        drive_params(mkp(0, 0, 0, 0, 0, 0, 0, 0));

        // p90, tau, p180, dns, sig, echoes -> done cycle, acq cycles, rf cycles
        p0 = mkp(0, 0, 3, 5, 6, 2, 4, 2);
        vecs.push_back(mkv(p0, 33, 8, 15));
        vecs.push_back(mkv(mkp(0, 0, 3, 5, 6, 2, 4, 0), 9, 0, 3));
        vecs.push_back(mkv(mkp(0, 0, 2, 0, 3, 0, 2, 3), 18, 6, 11));
        vecs.push_back(mkv(mkp(0, 0, 1, 1, 1, 1, 1, 1), 6, 1, 2));
        vecs.push_back(mkv(mkp(0, 0, 0, 2, 1, 0, 1, 2), 7, 2, 2));
`ifdef CPMG_T1_PRELUDE_EN
        vecs.push_back(mkv(mkp(4, 10, 3, 2, 1, 0, 1, 1), 22, 1, 8));
`else
        vecs.push_back(mkv(mkp(7, 3, 1, 1, 1, 1, 1, 1), 6, 1, 2));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(sample()), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_scan(vecs[i].p, 0, 0, $sformatf("vec%0d", i), dc, ac, rc);
            check($sformatf("vec%0d done_cycle", i), 64'(dc), 64'(vecs[i].done_cyc));
            check($sformatf("vec%0d acq_cycles", i), 64'(ac), 64'(vecs[i].acq_cnt));
            check($sformatf("vec%0d rf_cycles", i),  64'(rc), 64'(vecs[i].rf_cnt));
        end

`ifndef CPMG_T1_PRELUDE_EN
        // Abort on the 2nd cycle of the second SIG, then a normal scan.
        run_scan(p0, 30, 0, "abort", dc, ac, rc);
        check("abort no_done", 64'(dc), 64'd0);
        run_scan(p0, 0, 0, "after_abort", dc, ac, rc);
        check("after_abort done_cycle", 64'(dc), 64'd33);

        // Parameter change and second start mid-scan are ignored.
        run_scan(p0, 0, 10, "stable", dc, ac, rc);
        check("stable done_cycle", 64'(dc), 64'd33);
`endif

        // Abort wins over a same-cycle start in IDLE.
        @(negedge clk);
        drive_params(p0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("abort_over_start busy_later", 64'(busy), 64'd0);

        // Reset mid-scan ends the scan without done.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset busy", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_scan_reset outputs", 64'(sample()), 64'd0);
        reset     = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("mid_scan_reset quiet", 64'(seen_done), 64'd0);

        // Randomized scans against the model.
        for (int i = 0; i < 25; i++) begin
            pr = mkp($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4));
            run_scan(pr, 0, 0, $sformatf("rnd%0d", i), dc, ac, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpmg_sequencer.md
CPMG_SEQUENCER -- requirements
Module: cpmg_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: a one-cycle request to run one scan.
REQ-004 SHALL have port abort, input, 1 bit: synchronous request to terminate a scan.
REQ-005 SHALL have ports pulse_90deg, pulse_180deg, init_delay, delay_nosig, delay_sig, echoes_per_scan, pulse_t1, delay_t1: inputs, 32 bits each, unsigned cycle counts from the parameter PIOs.
REQ-006 SHALL have port rf_gate, output, 1 bit: transmitter enable.
REQ-007 SHALL have port rf_phase, output, 1 bit: 0 selects the 90/T1 phase, 1 selects the 180 phase.
REQ-008 SHALL have port rx_blank, output, 1 bit: receiver blanking.
REQ-009 SHALL have port acq_gate, output, 1 bit: ADC acquisition window.
REQ-010 SHALL have ports busy (1 bit), done (1 bit) and echo_idx (32 bits), all outputs.

Function
REQ-011 SHALL implement states IDLE, T1P, T1D, P90, TAU, P180, DNS, SIG, DONE.
REQ-012 SHALL latch all eight parameters on start accepted in IDLE; later parameter changes do not affect the running scan.
REQ-013 SHALL use this order: IDLE -> [T1P -> T1D] -> P90 -> TAU -> {P180 -> DNS -> SIG} x echoes_per_scan -> DONE -> IDLE.
REQ-014 SHALL occupy each timed state for exactly N cycles, where N is its latched parameter; a state with N=0 is skipped in zero cycles.
REQ-015 SHALL register all outputs: when start is sampled at edge k, the first timed state's outputs are valid from edge k+1.
REQ-016 SHALL drive outputs per state:
- T1P, P90: rf_gate=1, rf_phase=0.
- P180: rf_gate=1, rf_phase=1.
- rx_blank: 1 in T1P, P90, P180, DNS.
- acq_gate: 1 only in SIG.
- All four outputs are 0 elsewhere.
REQ-017 SHALL hold echo_idx at 0 until the first P180, then increment it on entry to each subsequent P180, so it equals the 0-based echo number.
REQ-018 SHALL skip the echo loop when echoes_per_scan=0 and go TAU -> DONE.
REQ-019 SHALL hold busy=1 in every state except IDLE.
REQ-020 SHALL pulse done high for exactly one cycle, in DONE.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL handle abort when busy=1 as follows: next edge goes to IDLE, all outputs are 0, done is not asserted, and echo_idx resets to 0.
REQ-023 SHALL give abort priority over start when both are sampled in the same cycle.
REQ-024 SHALL time each state with one 32-bit down-counter loaded on state entry; the state exits when the count reaches 1, and no wrap-around is permitted.
REQ-025 SHALL reach DONE after the SIG of echo echoes_per_scan-1, handling up to 2^32-1 echoes.

Reset
REQ-026 SHALL, on reset, enter IDLE and drive rf_gate, rf_phase, rx_blank, acq_gate, busy and done to 0.
REQ-027 SHALL, on reset, clear echo_idx, the duration counter and all latched parameters to 0.
REQ-028 SHALL give reset priority over abort and start, and reset mid-scan terminates the scan without asserting done.

Configuration
REQ-029 SHALL compile the T1 inversion-recovery prelude (T1P, T1D) only when CPMG_T1_PRELUDE_EN is defined; pulse_t1 and delay_t1 are then latched and used.
REQ-030 SHALL, without CPMG_T1_PRELUDE_EN, keep the pulse_t1 and delay_t1 ports but ignore them, never enter T1P or T1D, and go IDLE -> P90 directly.

Structure
REQ-031 SHALL place the state enum, the parameter width constant (32) and the rf_phase encodings in shared package cpmg_pkg.
REQ-032 SHALL implement the loadable 32-bit down-counter as sub-module cpmg_dur_cnt (inputs load and value; output last).

Verification
REQ-033 Basic scan, prelude off: p90=3, tau=5, p180=6, dns=2, sig=4, echoes=2; start at cycle 0. Required response: rf_gate high cycles 1-3, rf_phase=1 in cycles 9-14 and 21-26, acq_gate high cycles 17-20 and 29-32, done at cycle 33, busy low at cycle 34.
REQ-034 Zero echoes: echoes_per_scan=0. Required response: P90 and TAU only, done on the cycle after TAU, acq_gate never high, echo_idx=0.
REQ-035 Zero durations: dns=0, tau=0. Required response: P180 is followed directly by SIG, and P90 directly by P180, with no idle cycles.
REQ-036 Abort: abort asserted on the 2nd cycle of the second SIG. Required response: next cycle all outputs 0 and busy=0, no done; a new start then runs normally.
REQ-037 Prelude on (CPMG_T1_PRELUDE_EN): pulse_t1=4, delay_t1=10. Required response: rf_gate high cycles 1-4 with rf_phase=0, low cycles 5-14, P90 begins at cycle 15.
REQ-038 Parameter stability: change pulse_180deg and pulse 'start' mid-scan. Required response: timing is unchanged and the second start is ignored.
